// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU op codes,
// immediate formats and the ID/EX bundle layout.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_R = 3'd5
    } imm_type_e;

    // Side-effecting control bits; cleared on bubbles.
    typedef struct packed {
        logic src_a_pc;
        logic src_b_imm;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        alu_op_e   alu_op;
        imm_type_e imm_type;
        logic      use_rs1;
        logic      use_rs2;
        ctrl_t     ctrl;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        ctrl_t       ctrl;
    } id_ex_t;

    // funct3 -> ALU op for OP / OP-IMM.
    // SUB is only legal for register-register OP.
    function automatic alu_op_e alu_from_f3(
        input logic [2:0] f3,
        input logic       sub_ok,
        input logic       f7b5
    );
        case (f3)
            3'b000:  return (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: instr[31:7] + format -> 32-bit
// sign-extended immediate. Ports: instr, imm_type in; imm out.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    logic s;
    assign s = instr[31];

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{s}}, instr[31:20]};
            IMM_S: imm = {{20{s}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{s}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{s}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads and
// bypasses operands, detects load-use hazards and holds ID/EX.
// Ports: if_* fetch handshake, rf_* reg-file read, wb_* bypass,
// flush from branch resolution, ex_* ID/EX outputs + ex_ready.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    input  logic        wb_write_en,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [4:0]  ex_rd_addr,
    output logic [4:0]  ex_rs1_addr,
    output logic [4:0]  ex_rs2_addr,
    output logic [3:0]  ex_alu_op,
    output logic [2:0]  ex_funct3,
    output logic        ex_src_a_pc,
    output logic        ex_src_b_imm,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_illegal
);

    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        hazard;
    logic        stall;
    dec_t        dc;
    id_ex_t      dec_bundle;
    id_ex_t      id_ex_q;
    logic        valid_q;

    assign opc  = if_instr[6:0];
    assign rs1  = if_instr[19:15];
    assign rs2  = if_instr[24:20];
    assign f3   = if_instr[14:12];
    assign f7b5 = if_instr[30];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    always_comb begin
        dc          = '0;
        dc.alu_op   = ALU_ADD;
        dc.imm_type = IMM_R;
        unique case (1'b1)
            opc == OPC_LUI: begin
                dc.imm_type       = IMM_U;
                dc.alu_op         = ALU_PASS_B;
                dc.ctrl.src_b_imm = 1'b1;
                dc.ctrl.reg_write = 1'b1;
            end
            opc == OPC_AUIPC: begin
                dc.imm_type       = IMM_U;
                dc.ctrl.src_a_pc  = 1'b1;
                dc.ctrl.src_b_imm = 1'b1;
                dc.ctrl.reg_write = 1'b1;
            end
            opc == OPC_JAL: begin
                dc.imm_type       = IMM_J;
                dc.ctrl.src_a_pc  = 1'b1;
                dc.ctrl.src_b_imm = 1'b1;
                dc.ctrl.reg_write = 1'b1;
                dc.ctrl.jump      = 1'b1;
            end
            opc == OPC_JALR: begin
                dc.imm_type       = IMM_I;
                dc.use_rs1        = 1'b1;
                dc.ctrl.src_b_imm = 1'b1;
                dc.ctrl.reg_write = 1'b1;
                dc.ctrl.jump      = 1'b1;
            end
            opc == OPC_BRANCH: begin
                dc.imm_type    = IMM_B;
                dc.alu_op      = ALU_SUB;
                dc.use_rs1     = 1'b1;
                dc.use_rs2     = 1'b1;
                dc.ctrl.branch = 1'b1;
            end
            opc == OPC_LOAD: begin
                dc.imm_type       = IMM_I;
                dc.use_rs1        = 1'b1;
                dc.ctrl.src_b_imm = 1'b1;
                dc.ctrl.reg_write = 1'b1;
                dc.ctrl.mem_read  = 1'b1;
            end
            opc == OPC_STORE: begin
                dc.imm_type       = IMM_S;
                dc.use_rs1        = 1'b1;
                dc.use_rs2        = 1'b1;
                dc.ctrl.src_b_imm = 1'b1;
                dc.ctrl.mem_write = 1'b1;
            end
            opc == OPC_OP_IMM: begin
                dc.imm_type       = IMM_I;
                dc.alu_op         = alu_from_f3(f3, 1'b0, f7b5);
                dc.use_rs1        = 1'b1;
                dc.ctrl.src_b_imm = 1'b1;
                dc.ctrl.reg_write = 1'b1;
            end
            opc == OPC_OP: begin
                dc.alu_op         = alu_from_f3(f3, 1'b1, f7b5);
                dc.use_rs1        = 1'b1;
                dc.use_rs2        = 1'b1;
                dc.ctrl.reg_write = 1'b1;
            end
            opc == OPC_MISC: begin
                dc.imm_type = IMM_I;
            end
            opc == OPC_SYSTEM: begin
                dc.imm_type     = IMM_I;
                dc.ctrl.illegal = 1'b1;
            end
            default: begin
                dc.ctrl.illegal = 1'b1;
            end
        endcase
    end

    imm_gen u_imm_gen (
        .instr    (if_instr[31:7]),
        .imm_type (dc.imm_type),
        .imm      (imm)
    );

    // x0 reads as zero, so a writeback to x0 can never bypass.
    function automatic logic [31:0] read_op(
        input logic [4:0]  idx,
        input logic [31:0] rf_data
    );
        if (idx == 5'd0)
            return 32'd0;
        if (wb_write_en && wb_rd_addr == idx)
            return wb_rd_data;
        return rf_data;
    endfunction

    assign op1 = read_op(rs1, rf_read_data1);
    assign op2 = read_op(rs2, rf_read_data2);

    always_comb begin
        dec_bundle          = '0;
        dec_bundle.pc       = if_pc;
        dec_bundle.imm      = imm;
        dec_bundle.rs1_data = op1;
        dec_bundle.rs2_data = op2;
        dec_bundle.rd       = if_instr[11:7];
        dec_bundle.rs1      = dc.use_rs1 ? rs1 : 5'd0;
        dec_bundle.rs2      = dc.use_rs2 ? rs2 : 5'd0;
        dec_bundle.funct3   = f3;
        dec_bundle.alu_op   = dc.alu_op;
        dec_bundle.ctrl     = dc.ctrl;
    end

    assign stall  = valid_q && !ex_ready;
    assign hazard = if_valid && valid_q
                  && id_ex_q.ctrl.mem_read
                  && id_ex_q.rd != 5'd0
                  && ((dc.use_rs1 && rs1 == id_ex_q.rd)
                   || (dc.use_rs2 && rs2 == id_ex_q.rd));

    // flush forces acceptance so the offered word is discarded.
    assign if_ready = flush || (!stall && !hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            id_ex_q    <= '0;
            id_ex_q.pc <= RESET_PC;
        end else if (flush) begin
            valid_q      <= 1'b0;
            id_ex_q.ctrl <= '0;
        end else if (!stall) begin
            if (!hazard && if_valid) begin
                valid_q <= 1'b1;
                id_ex_q <= dec_bundle;
            end else begin
                valid_q      <= 1'b0;
                id_ex_q.ctrl <= '0;
            end
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = id_ex_q.pc;
    assign ex_imm       = id_ex_q.imm;
    assign ex_rs1_data  = id_ex_q.rs1_data;
    assign ex_rs2_data  = id_ex_q.rs2_data;
    assign ex_rd_addr   = id_ex_q.rd;
    assign ex_rs1_addr  = id_ex_q.rs1;
    assign ex_rs2_addr  = id_ex_q.rs2;
    assign ex_alu_op    = id_ex_q.alu_op;
    assign ex_funct3    = id_ex_q.funct3;
    assign ex_src_a_pc  = id_ex_q.ctrl.src_a_pc;
    assign ex_src_b_imm = id_ex_q.ctrl.src_b_imm;
    assign ex_reg_write = id_ex_q.ctrl.reg_write;
    assign ex_mem_read  = id_ex_q.ctrl.mem_read;
    assign ex_mem_write = id_ex_q.ctrl.mem_write;
    assign ex_branch    = id_ex_q.ctrl.branch;
    assign ex_jump      = id_ex_q.ctrl.jump;
    assign ex_illegal   = id_ex_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-computed vectors for
// decode, bypass, load-use, backpressure, flush and reset.
module tb_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        if_ready;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_read_data1 = '0;
    logic [31:0] rf_read_data2 = '0;
    logic        wb_write_en = 1'b0;
    logic [4:0]  wb_rd_addr = '0;
    logic [31:0] wb_rd_data = '0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic [4:0]  ex_rs1_addr;
    logic [4:0]  ex_rs2_addr;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic        ex_src_a_pc;
    logic        ex_src_b_imm;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_illegal;

    int vecs = 0;
    int errs = 0;

    decode_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_ready(if_ready),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_read_data1(rf_read_data1),
        .rf_read_data2(rf_read_data2),
        .wb_write_en(wb_write_en), .wb_rd_addr(wb_rd_addr),
        .wb_rd_data(wb_rd_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_rs1_addr(ex_rs1_addr),
        .ex_rs2_addr(ex_rs2_addr), .ex_alu_op(ex_alu_op),
        .ex_funct3(ex_funct3), .ex_src_a_pc(ex_src_a_pc),
        .ex_src_b_imm(ex_src_b_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins,
                         input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        if_instr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vecs++;
        if ({ex_valid, ex_pc, ex_imm, ex_reg_write, ex_illegal}
            !== {1'b0, RPC, 32'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_state: valid=%b pc=%h imm=%h rw=%b ill=%b",
                     ex_valid, ex_pc, ex_imm, ex_reg_write, ex_illegal);
        end
        rst = 1'b0;
        step();
        vecs++;
        if (if_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_if_ready: got %b want 1", if_ready);
        end
    endtask

    task automatic test_addi();
        offer(32'h0050_0093, 32'h100);
        step();
        idle();
        vecs++;
        if ({ex_valid, ex_imm, ex_rd_addr, ex_pc}
            !== {1'b1, 32'd5, 5'd1, 32'h100}) begin
            errs++;
            $display("FAIL addi_data: v=%b imm=%h rd=%0d pc=%h want 1/5/1/100",
                     ex_valid, ex_imm, ex_rd_addr, ex_pc);
        end
        vecs++;
        if ({ex_alu_op, ex_src_b_imm, ex_reg_write, ex_rs2_addr}
            !== {4'd0, 1'b1, 1'b1, 5'd0}) begin
            errs++;
            $display("FAIL addi_ctrl: alu=%0d bimm=%b rw=%b rs2a=%0d want 0/1/1/0",
                     ex_alu_op, ex_src_b_imm, ex_reg_write, ex_rs2_addr);
        end
    endtask

    task automatic test_branch();
        offer(32'hFE20_8EE3, 32'h104);
        step();
        idle();
        vecs++;
        if ({ex_imm, ex_branch, ex_alu_op, ex_reg_write, ex_rs2_addr}
            !== {32'hFFFF_FFFC, 1'b1, 4'd1, 1'b0, 5'd2}) begin
            errs++;
            $display("FAIL beq: imm=%h br=%b alu=%0d rw=%b rs2a=%0d want fffffffc/1/1/0/2",
                     ex_imm, ex_branch, ex_alu_op, ex_reg_write, ex_rs2_addr);
        end
    endtask

    task automatic test_load_use();
        offer(32'h0000_A103, 32'h200);
        step();
        offer(32'h0011_01B3, 32'h204);
        #1;
        vecs++;
        if ({ex_valid, ex_mem_read, if_ready} !== 3'b110) begin
            errs++;
            $display("FAIL lu_stall: v=%b mr=%b rdy=%b want 1/1/0",
                     ex_valid, ex_mem_read, if_ready);
        end
        step();
        vecs++;
        if ({ex_valid, ex_mem_read, ex_reg_write, if_ready} !== 4'b0001) begin
            errs++;
            $display("FAIL lu_bubble: v=%b mr=%b rw=%b rdy=%b want 0/0/0/1",
                     ex_valid, ex_mem_read, ex_reg_write, if_ready);
        end
        step();
        idle();
        vecs++;
        if ({ex_valid, ex_rd_addr, ex_rs1_addr, ex_rs2_addr, ex_pc}
            !== {1'b1, 5'd3, 5'd2, 5'd1, 32'h204}) begin
            errs++;
            $display("FAIL lu_add: v=%b rd=%0d rs1=%0d rs2=%0d pc=%h",
                     ex_valid, ex_rd_addr, ex_rs1_addr, ex_rs2_addr, ex_pc);
        end
    endtask

    task automatic test_bypass();
        rf_read_data1 = 32'd0;
        wb_write_en   = 1'b1;
        wb_rd_addr    = 5'd5;
        wb_rd_data    = 32'hDEAD_BEEF;
        offer(32'h0002_8333, 32'h300);
        step();
        vecs++;
        if ({ex_rs1_data, ex_rs2_data}
            !== {32'hDEAD_BEEF, 32'd0}) begin
            errs++;
            $display("FAIL bypass_hit: rs1=%h rs2=%h want deadbeef/0",
                     ex_rs1_data, ex_rs2_data);
        end
        wb_rd_addr    = 5'd0;
        rf_read_data1 = 32'h1111_1111;
        step();
        vecs++;
        if (ex_rs1_data !== 32'h1111_1111) begin
            errs++;
            $display("FAIL bypass_wb_x0: rs1=%h want 11111111",
                     ex_rs1_data);
        end
        // add x6,x0,x0: index 0 reads zero whatever rf/wb show.
        rf_read_data1 = 32'h2222_2222;
        offer(32'h0000_0333, 32'h308);
        step();
        idle();
        wb_write_en = 1'b0;
        rf_read_data1 = 32'd0;
        vecs++;
        if (ex_rs1_data !== 32'd0) begin
            errs++;
            $display("FAIL bypass_x0_src: rs1=%h want 0", ex_rs1_data);
        end
    endtask

    task automatic test_backpressure();
        offer(32'h0050_0093, 32'h400);
        step();
        ex_ready = 1'b0;
        offer(32'h0070_0113, 32'h404);
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if ({if_ready, ex_valid, ex_imm, ex_pc, ex_rd_addr}
                !== {1'b0, 1'b1, 32'd5, 32'h400, 5'd1}) begin
                errs++;
                $display("FAIL bp_hold%0d: rdy=%b v=%b imm=%h pc=%h rd=%0d",
                         i, if_ready, ex_valid, ex_imm, ex_pc, ex_rd_addr);
            end
            step();
        end
        ex_ready = 1'b1;
        #1;
        vecs++;
        if (if_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_release_rdy: got %b want 1", if_ready);
        end
        step();
        idle();
        vecs++;
        if ({ex_valid, ex_imm, ex_pc, ex_rd_addr}
            !== {1'b1, 32'd7, 32'h404, 5'd2}) begin
            errs++;
            $display("FAIL bp_next: v=%b imm=%h pc=%h rd=%0d want 1/7/404/2",
                     ex_valid, ex_imm, ex_pc, ex_rd_addr);
        end
    endtask

    task automatic test_flush();
        offer(32'h0050_0093, 32'h500);
        step();
        ex_ready = 1'b0;
        flush    = 1'b1;
        offer(32'h0070_0113, 32'h504);
        #1;
        vecs++;
        if (if_ready !== 1'b1) begin
            errs++;
            $display("FAIL flush_rdy: got %b want 1", if_ready);
        end
        step();
        flush = 1'b0;
        idle();
        vecs++;
        if ({ex_valid, ex_reg_write} !== 2'b00) begin
            errs++;
            $display("FAIL flush_kill: v=%b rw=%b want 0/0",
                     ex_valid, ex_reg_write);
        end
        ex_ready = 1'b1;
        step();
        vecs++;
        if (ex_valid !== 1'b0) begin
            errs++;
            $display("FAIL flush_drop: v=%b want 0", ex_valid);
        end
        // flush together with a load-use hazard
        offer(32'h0000_A103, 32'h508);
        step();
        offer(32'h0011_01B3, 32'h50C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        vecs++;
        if ({ex_valid, if_ready} !== 2'b01) begin
            errs++;
            $display("FAIL flush_hazard: v=%b rdy=%b want 0/1",
                     ex_valid, if_ready);
        end
        step();
        idle();
        vecs++;
        if ({ex_valid, ex_rd_addr, ex_pc} !== {1'b1, 5'd3, 32'h50C}) begin
            errs++;
            $display("FAIL flush_hazard_next: v=%b rd=%0d pc=%h want 1/3/50c",
                     ex_valid, ex_rd_addr, ex_pc);
        end
    endtask

    task automatic test_rst_mid_stall();
        offer(32'h0000_A103, 32'h600);
        step();
        ex_ready = 1'b0;
        offer(32'h0011_01B3, 32'h604);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        ex_ready = 1'b1;
        vecs++;
        if ({ex_valid, ex_pc, ex_imm, ex_mem_read, ex_rd_addr}
            !== {1'b0, RPC, 32'd0, 1'b0, 5'd0}) begin
            errs++;
            $display("FAIL rst_mid: v=%b pc=%h imm=%h mr=%b rd=%0d",
                     ex_valid, ex_pc, ex_imm, ex_mem_read, ex_rd_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [8];
        logic [39:0] exp [8];
        logic [39:0] got;
        // {alu_op, imm, src_a_pc, src_b_imm, reg_write, illegal}
        ins[0] = 32'h4031_00B3; exp[0] = {4'd1,  32'd0,        4'b0010};
        ins[1] = 32'h4031_5093; exp[1] = {4'd7,  32'h403,      4'b0110};
        ins[2] = 32'h1234_52B7; exp[2] = {4'd10, 32'h1234_5000, 4'b0110};
        ins[3] = 32'h0000_1097; exp[3] = {4'd0,  32'h1000,     4'b1110};
        ins[4] = 32'h0080_00EF; exp[4] = {4'd0,  32'd8,        4'b1110};
        ins[5] = 32'h0000_000F; exp[5] = {4'd0,  32'd0,        4'b0000};
        ins[6] = 32'h0000_0073; exp[6] = {4'd0,  32'd0,        4'b0001};
        ins[7] = 32'hFFFF_FFFF; exp[7] = {4'd0,  32'd0,        4'b0001};
        for (int i = 0; i < 8; i++) begin
            offer(ins[i], 32'h700 + 32'(i * 4));
            step();
            got = {ex_alu_op, ex_imm, ex_src_a_pc, ex_src_b_imm,
                   ex_reg_write, ex_illegal};
            vecs++;
            if (got !== exp[i] || ex_valid !== 1'b1) begin
                errs++;
                $display("FAIL b2b_%0d: v=%b got %h want %h",
                         i, ex_valid, got, exp[i]);
            end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_load_use();
        test_bypass();
        test_backpressure();
        test_flush();
        test_rst_mid_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
